// File: rtl/mem_bus_decoder_pkg.sv
// rtl/mem_bus_decoder_pkg.sv - shared FSM encodings and defaults for the native-bus decoder
package mem_bus_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // How the access in flight will be terminated once BUSY is entered
    typedef enum logic [1:0] {
        K_UNMAPPED = 2'd0,
        K_SYNC     = 2'd1,
        K_SELF     = 2'd2
    } kind_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - wait-cycle counter for self-timed slaves with TIMEOUT compare
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == CW'(TIMEOUT));

    // Increment stops at TIMEOUT so the counter can never wrap
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CW'(1);
        end else if (inc_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - picorv32 native-bus region decoder, ready generation and error capture
module mem_bus_decoder
    import mem_bus_decoder_pkg::*;
#(
    parameter int unsigned           NUM_SLAVES = 8,
    parameter int unsigned           SEL_BITS   = 4,
    parameter int unsigned           SEL_LSB    = 12,
    parameter logic [NUM_SLAVES-1:0] SYNC_MASK  = 8'b0000_0111,
    parameter int unsigned           TIMEOUT    = 255,
    parameter logic [31:0]           ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_valid,
    input  logic [31:0]               cpu_addr,
    input  logic [3:0]                cpu_wstrb,
    output logic                      cpu_ready,
    output logic [31:0]               cpu_rdata,
    output logic [NUM_SLAVES-1:0]     slv_cs,
    input  logic [NUM_SLAVES-1:0]     slv_ready,
    input  logic [32*NUM_SLAVES-1:0]  slv_rdata,
    input  logic                      err_clr,
    output logic                      bus_err,
    output logic [31:0]               err_addr
);

    state_t              state_q, state_d;
    kind_t               kind_q, kind_d;
    logic [SEL_BITS-1:0] sel, sel_q, sel_d, idx;
    logic                mapped;
    logic                sel_rdy, sel_sync;
    logic [31:0]         sel_rdata;
    logic                ready;
    logic [31:0]         rdata;
    logic                err_set;
    logic                wd_load, wd_inc, wd_clr, wd_expired;
    logic                bus_err_q, bus_err_d;
    logic [31:0]         err_addr_q, err_addr_d;
    logic                cs_en;
    logic                wstrb_unused;

    // Write strobes reach the slaves directly from the cpu; the decoder only gates chip selects
    assign wstrb_unused = |cpu_wstrb;

    assign sel    = cpu_addr[SEL_LSB +: SEL_BITS];
    assign mapped = 32'(sel) < NUM_SLAVES;
    assign idx    = (state_q == ST_BUSY) ? sel_q : sel;

    always_comb begin
        sel_rdy   = 1'b0;
        sel_sync  = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx == SEL_BITS'(i)) begin
                sel_rdy   = slv_ready[i];
                sel_sync  = SYNC_MASK[i];
                sel_rdata = slv_rdata[32*i +: 32];
            end
        end
    end

    // Chip selects are combinational so a BRAM sees the address in the request cycle
    assign cs_en = cpu_valid && rst_n && (state_q == ST_IDLE || state_q == ST_BUSY);

    always_comb begin
        slv_cs = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            slv_cs[i] = cs_en && (sel == SEL_BITS'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        sel_d   = sel_q;
        ready   = 1'b0;
        rdata   = '0;
        err_set = 1'b0;
        wd_load = 1'b0;
        wd_inc  = 1'b0;
        wd_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    sel_d = sel;
                    if (!mapped) begin
                        kind_d  = K_UNMAPPED;
                        state_d = ST_BUSY;
                    end else if (sel_sync) begin
                        kind_d  = K_SYNC;
                        state_d = ST_BUSY;
                    end else if (sel_rdy) begin
                        ready   = 1'b1;
                        rdata   = sel_rdata;
                        state_d = ST_GAP;
                    end else begin
                        kind_d  = K_SELF;
                        wd_load = 1'b1;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (!cpu_valid) begin
                    wd_clr  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    case (kind_q)
                        K_UNMAPPED: begin
                            ready   = 1'b1;
                            rdata   = ERR_DATA;
                            err_set = 1'b1;
                            state_d = ST_GAP;
                        end
                        K_SYNC: begin
                            ready   = 1'b1;
                            rdata   = sel_rdata;
                            state_d = ST_GAP;
                        end
                        K_SELF: begin
                            // A slave answering on the last allowed cycle still wins over the timeout
                            if (sel_rdy) begin
                                ready   = 1'b1;
                                rdata   = sel_rdata;
                                wd_clr  = 1'b1;
                                state_d = ST_GAP;
                            end else if (wd_expired) begin
                                ready   = 1'b1;
                                rdata   = ERR_DATA;
                                err_set = 1'b1;
                                wd_clr  = 1'b1;
                                state_d = ST_GAP;
                            end else begin
                                wd_inc = 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus_err_d  = err_set ? 1'b1 : (err_clr ? 1'b0 : bus_err_q);
    assign err_addr_d = err_set ? cpu_addr : err_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            kind_q     <= K_UNMAPPED;
            sel_q      <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            sel_q      <= sel_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (wd_load),
        .inc_i     (wd_inc),
        .clr_i     (wd_clr),
        .expired_o (wd_expired)
    );

    assign cpu_ready = ready && rst_n;
    assign cpu_rdata = rst_n ? rdata : '0;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb/tb_mem_bus_decoder.sv - self-checking bench for mem_bus_decoder against a latency/data model
module tb_mem_bus_decoder;

    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_valid;
    logic [31:0]  cpu_addr;
    logic [3:0]   cpu_wstrb;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic [7:0]   slv_cs;
    logic [7:0]   slv_ready;
    logic [255:0] slv_rdata;
    logic         err_clr;
    logic         bus_err;
    logic [31:0]  err_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_word [8];
    logic        m_err;
    logic [31:0] m_err_addr;

    always #5 clk = ~clk;

    mem_bus_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_valid (cpu_valid),
        .cpu_addr  (cpu_addr),
        .cpu_wstrb (cpu_wstrb),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .slv_cs    (slv_cs),
        .slv_ready (slv_ready),
        .slv_rdata (slv_rdata),
        .err_clr   (err_clr),
        .bus_err   (bus_err),
        .err_addr  (err_addr)
    );

    task automatic load_rdata();
        for (int i = 0; i < 8; i++) slv_rdata[32*i +: 32] = mem_word[i];
    endtask

    // Reference: regions 0..2 answer after one wait, 3..7 when their slave says so (max 255), 8..15 fault
    task automatic model(input logic [31:0] addr, input int rdy_after,
                         output int lat, output logic [31:0] data, output bit err);
        int sel;
        sel = int'(addr[15:12]);
        err = 1'b0;
        if (sel >= 8) begin
            lat = 1; data = DEAD; err = 1'b1;
        end else if (sel < 3) begin
            lat = 1; data = mem_word[sel];
        end else if (rdy_after < 0 || rdy_after > 255) begin
            lat = 255; data = DEAD; err = 1'b1;
        end else begin
            lat = rdy_after; data = mem_word[sel];
        end
    endtask

    task automatic model_err(input bit err, input bit clr, input logic [31:0] addr);
        if (err) begin
            m_err = 1'b1;
            m_err_addr = addr;
        end else if (clr) begin
            m_err = 1'b0;
        end
    endtask

    // Drives one access from IDLE; returns at posedge+1 with the DUT back in IDLE
    task automatic access(input logic [31:0] addr, input logic [3:0] wstrb, input int rdy_after,
                          input bit clr, output int lat, output logic [31:0] data,
                          output int cs_bad, output bit gap_ok);
        int sel;
        logic [7:0] exp_cs;
        sel = int'(addr[15:12]);
        exp_cs = (sel < 8) ? 8'(1 << sel) : 8'h00;
        lat = -1; data = '0; cs_bad = 0; gap_ok = 1'b0;
        cpu_valid = 1'b1; cpu_addr = addr; cpu_wstrb = wstrb; err_clr = clr;
        for (int c = 0; c < 300; c++) begin
            slv_ready = (rdy_after >= 0 && c >= rdy_after) ? 8'hFF : 8'h00;
            #4;
            if (slv_cs !== exp_cs) cs_bad++;
            if (cpu_ready === 1'b1) begin
                lat = c;
                data = cpu_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            err_clr = 1'b0; slv_ready = 8'hFF;
            #4;
            gap_ok = (cpu_ready === 1'b0) && (slv_cs === 8'h00);
        end
        @(posedge clk); #1;
        cpu_valid = 1'b0; slv_ready = 8'h00; err_clr = 1'b0;
        if (lat < 0) begin
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_valid = 1'b1; cpu_addr = 32'h0; cpu_wstrb = 4'h0;
        slv_ready = 8'hFF; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1; #4;
        checks++; if (slv_cs !== 8'h00) begin errors++; $display("FAIL reset_cs got %h exp 00", slv_cs); end
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", cpu_rdata); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h exp 0", err_addr); end
        @(posedge clk); #1;
        rst_n = 1'b1; cpu_valid = 1'b0; slv_ready = 8'h00;
        @(posedge clk); #1;
        m_err = 1'b0; m_err_addr = '0;
    endtask

    task automatic test_sync_read();
        int lat, elat, csb; logic [31:0] d, ed; bit gok, eerr;
        model(32'h0000_0010, -1, elat, ed, eerr);
        access(32'h0000_0010, 4'h0, -1, 1'b0, lat, d, csb, gok);
        checks++; if (lat !== elat) begin errors++; $display("FAIL sync_lat got %0d exp %0d", lat, elat); end
        checks++; if (d !== ed) begin errors++; $display("FAIL sync_rdata got %h exp %h", d, ed); end
        checks++; if (csb !== 0) begin errors++; $display("FAIL sync_cs bad_cycles %0d exp 0", csb); end
        checks++; if (!gok) begin errors++; $display("FAIL sync_gap got active exp idle"); end
    endtask

    task automatic test_selftimed_write();
        int lat, elat, csb; logic [31:0] d, ed; bit gok, eerr;
        model(32'h0000_3000, 0, elat, ed, eerr);
        access(32'h0000_3000, 4'hF, 0, 1'b0, lat, d, csb, gok);
        checks++; if (lat !== elat) begin errors++; $display("FAIL wr3_lat got %0d exp %0d", lat, elat); end
        checks++; if (csb !== 0) begin errors++; $display("FAIL wr3_cs bad_cycles %0d exp 0", csb); end
        checks++; if (!gok) begin errors++; $display("FAIL wr3_gap got active exp idle"); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL wr3_bus_err got %b exp 0", bus_err); end
    endtask

    task automatic test_selftimed_delay();
        int lat, elat, csb; logic [31:0] d, ed; bit gok, eerr;
        model(32'h0000_4004, 5, elat, ed, eerr);
        access(32'h0000_4004, 4'h0, 5, 1'b0, lat, d, csb, gok);
        checks++; if (lat !== elat) begin errors++; $display("FAIL st4_lat got %0d exp %0d", lat, elat); end
        checks++; if (d !== ed) begin errors++; $display("FAIL st4_rdata got %h exp %h", d, ed); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL st4_bus_err got %b exp 0", bus_err); end
        model(32'h0000_4008, 2, elat, ed, eerr);
        access(32'h0000_4008, 4'h0, 2, 1'b0, lat, d, csb, gok);
        checks++; if (lat !== elat) begin errors++; $display("FAIL st4b_lat got %0d exp %0d", lat, elat); end
    endtask

    task automatic test_timeout();
        int lat, elat, csb; logic [31:0] d, ed; bit gok, eerr;
        model(32'h0000_5000, -1, elat, ed, eerr);
        access(32'h0000_5000, 4'h0, -1, 1'b0, lat, d, csb, gok);
        model_err(eerr, 1'b0, 32'h0000_5000);
        checks++; if (lat !== elat) begin errors++; $display("FAIL to_lat got %0d exp %0d", lat, elat); end
        checks++; if (d !== ed) begin errors++; $display("FAIL to_rdata got %h exp %h", d, ed); end
        checks++; if (bus_err !== m_err) begin errors++; $display("FAIL to_bus_err got %b exp %b", bus_err, m_err); end
        checks++; if (err_addr !== m_err_addr) begin errors++; $display("FAIL to_err_addr got %h exp %h", err_addr, m_err_addr); end
    endtask

    task automatic test_unmapped();
        int lat, elat, csb; logic [31:0] d, ed; bit gok, eerr;
        model(32'h0000_F000, -1, elat, ed, eerr);
        access(32'h0000_F000, 4'h0, -1, 1'b0, lat, d, csb, gok);
        model_err(eerr, 1'b0, 32'h0000_F000);
        checks++; if (lat !== elat) begin errors++; $display("FAIL um_lat got %0d exp %0d", lat, elat); end
        checks++; if (d !== ed) begin errors++; $display("FAIL um_rdata got %h exp %h", d, ed); end
        checks++; if (csb !== 0) begin errors++; $display("FAIL um_cs bad_cycles %0d exp 0", csb); end
        checks++; if (err_addr !== m_err_addr) begin errors++; $display("FAIL um_err_addr got %h exp %h", err_addr, m_err_addr); end
        model(32'h0000_9004, -1, elat, ed, eerr);
        access(32'h0000_9004, 4'h3, -1, 1'b1, lat, d, csb, gok);
        model_err(eerr, 1'b1, 32'h0000_9004);
        checks++; if (bus_err !== m_err) begin errors++; $display("FAIL um_set_wins got %b exp %b", bus_err, m_err); end
        checks++; if (err_addr !== m_err_addr) begin errors++; $display("FAIL um2_err_addr got %h exp %h", err_addr, m_err_addr); end
        model(32'h0000_1000, -1, elat, ed, eerr);
        access(32'h0000_1000, 4'h0, -1, 1'b1, lat, d, csb, gok);
        model_err(eerr, 1'b1, 32'h0000_1000);
        checks++; if (bus_err !== m_err) begin errors++; $display("FAIL um_clr got %b exp %b", bus_err, m_err); end
    endtask

    task automatic test_abort();
        int lat, elat, csb, rdy_seen; logic [31:0] d, ed; bit gok, eerr;
        cpu_valid = 1'b1; cpu_addr = 32'h0000_6000; cpu_wstrb = 4'h0; slv_ready = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        rdy_seen = 0;
        repeat (3) begin
            #4;
            if (cpu_ready !== 1'b0) rdy_seen++;
            @(posedge clk); #1;
        end
        checks++; if (rdy_seen !== 0) begin errors++; $display("FAIL abort_ready got %0d pulses exp 0", rdy_seen); end
        checks++; if (bus_err !== m_err) begin errors++; $display("FAIL abort_bus_err got %b exp %b", bus_err, m_err); end
        model(32'h0000_6000, 4, elat, ed, eerr);
        access(32'h0000_6000, 4'h0, 4, 1'b0, lat, d, csb, gok);
        checks++; if (lat !== elat) begin errors++; $display("FAIL abort_next_lat got %0d exp %0d", lat, elat); end
    endtask

    task automatic test_reset_mid();
        int lat, elat, csb; logic [31:0] d, ed; bit gok, eerr;
        access(32'h0000_A000, 4'h0, -1, 1'b0, lat, d, csb, gok);
        cpu_valid = 1'b1; cpu_addr = 32'h0000_5000; slv_ready = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #4;
        checks++; if (slv_cs !== 8'h00 || cpu_ready !== 1'b0) begin errors++; $display("FAIL rstmid_now cs %h ready %b exp 00 0", slv_cs, cpu_ready); end
        @(posedge clk); #1; #4;
        checks++; if (slv_cs !== 8'h00 || cpu_ready !== 1'b0) begin errors++; $display("FAIL rstmid_next cs %h ready %b exp 00 0", slv_cs, cpu_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1; cpu_valid = 1'b0;
        m_err = 1'b0; m_err_addr = '0;
        #4;
        checks++; if (bus_err !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL rstmid_err got %b %h exp 0 0", bus_err, err_addr); end
        @(posedge clk); #1;
        model(32'h0000_0100, -1, elat, ed, eerr);
        access(32'h0000_0100, 4'h0, -1, 1'b0, lat, d, csb, gok);
        checks++; if (lat !== elat || d !== ed) begin errors++; $display("FAIL rstmid_read lat %0d data %h exp %0d %h", lat, d, elat, ed); end
    endtask

    task automatic test_back_to_back();
        int lat, elat, csb, sel, r, rdy; logic [31:0] d, ed, addr; logic [3:0] ws; bit gok, eerr, clr;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 15);
            addr = $urandom();
            addr[15:12] = 4'(sel);
            r = $urandom_range(0, 9);
            rdy = (r == 9) ? -1 : r;
            clr = ($urandom_range(0, 3) == 0);
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
            if (sel < 8) begin
                mem_word[sel] = $urandom();
                load_rdata();
            end
            model(addr, rdy, elat, ed, eerr);
            access(addr, ws, rdy, clr, lat, d, csb, gok);
            model_err(eerr, clr, addr);
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_lat addr %h got %0d exp %0d", n, addr, lat, elat); end
            checks++; if (d !== ed) begin errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, d, ed); end
            checks++; if (csb !== 0) begin errors++; $display("FAIL rnd%0d_cs bad_cycles %0d exp 0", n, csb); end
            checks++; if (!gok) begin errors++; $display("FAIL rnd%0d_gap got active exp idle", n); end
            checks++; if (bus_err !== m_err) begin errors++; $display("FAIL rnd%0d_bus_err got %b exp %b", n, bus_err, m_err); end
            checks++; if (err_addr !== m_err_addr) begin errors++; $display("FAIL rnd%0d_err_addr got %h exp %h", n, err_addr, m_err_addr); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem_word[i] = $urandom();
        slv_rdata = '0;
        load_rdata();
        m_err = 1'b0; m_err_addr = '0;
        @(posedge clk); #1;
        test_reset();
        test_sync_read();
        test_selftimed_write();
        test_selftimed_delay();
        test_timeout();
        test_unmapped();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
